// File: rtl/local_mem_cmd_seq_if.sv
// ============================================================================
// Module   : local_mem_cmd_seq_if
// Brief    : Request/response channel between a client and local_mem_cmd_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface local_mem_cmd_seq_if #(
  parameter int DATA_WIDTH = 64
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_op;
  logic                  req_bank;
  logic [DATA_WIDTH-1:0] req_address;
  logic [DATA_WIDTH-1:0] req_writedata;
  logic [7:0]            req_byteenable;
  logic [2:0]            req_word_sel;
  logic [6:0]            req_burstcount;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_status;

  modport master (
    output req_valid, req_op, req_bank, req_address, req_writedata,
           req_byteenable, req_word_sel, req_burstcount, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_status
  );

  modport slave (
    input  req_valid, req_op, req_bank, req_address, req_writedata,
           req_byteenable, req_word_sel, req_burstcount, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_status
  );

endinterface

`default_nettype wire

// File: rtl/local_mem_cmd_seq.sv
// ============================================================================
// Module   : local_mem_cmd_seq
// Brief    : One-at-a-time command sequencer for the local_mem CSR control
//            port; issues a ctrl pulse and converts status flags to a response.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module local_mem_cmd_seq #(
  parameter int DATA_WIDTH     = 64,
  parameter int GUARD_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ERR_CNT_W      = 16
) (
  input  wire logic                  pClk,
  input  wire logic                  SoftReset,
  local_mem_cmd_seq_if.slave         bus,
  output logic [DATA_WIDTH-1:0]      cr2mem_ctrl,
  output logic [DATA_WIDTH-1:0]      cr2mem_address,
  output logic [DATA_WIDTH-1:0]      cr2mem_writedata,
  input  wire logic [DATA_WIDTH-1:0] mem2cr_status,
  input  wire logic [DATA_WIDTH-1:0] mem2cr_readdata,
  output logic                       busy,
  output logic [ERR_CNT_W-1:0]       err_count
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int GRD_W = $clog2(GUARD_CYCLES) + 1;
  localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GRD_W-1:0] c_grd_last = GRD_W'(GUARD_CYCLES - 1);
  localparam logic [1:0] c_st_ok      = 2'b00;
  localparam logic [1:0] c_st_dev_to  = 2'b01;
  localparam logic [1:0] c_st_seq_to  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHK_FULL  = 3'd1,
    S_ISSUE     = 3'd2,
    S_GUARD     = 3'd3,
    S_WAIT_DATA = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [TMR_W-1:0]      r_timer;
  logic [TMR_W-1:0]      w_timer_nxt;
  logic [GRD_W-1:0]      r_guard;
  logic [GRD_W-1:0]      w_guard_nxt;

  logic                  r_op;
  logic                  r_bank;
  logic [DATA_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [7:0]            r_be;
  logic [2:0]            r_word_sel;
  logic [6:0]            r_burst;

  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]            r_rsp_status;
  logic [DATA_WIDTH-1:0] w_rsp_data_nxt;
  logic [1:0]            w_rsp_status_nxt;
  logic                  w_accept;

  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_cr_addr;
  logic [DATA_WIDTH-1:0] r_cr_wdata;
  logic                  r_busy;
  logic [ERR_CNT_W-1:0]  r_err_count;

  logic                  w_fifo_full;
  logic                  w_wr_timeout;
  logic                  w_rd_timeout;
  logic                  w_data_valid;
  logic [DATA_WIDTH-1:0] w_cmd;
  logic                  w_unused_status;

  // Bank-specific status flags; upper status bits carry nothing we act on.
  assign w_data_valid    = mem2cr_status[0];
  assign w_wr_timeout    = r_bank ? mem2cr_status[4] : mem2cr_status[1];
  assign w_rd_timeout    = r_bank ? mem2cr_status[5] : mem2cr_status[2];
  assign w_fifo_full     = r_bank ? mem2cr_status[6] : mem2cr_status[3];
  assign w_unused_status = ^mem2cr_status[DATA_WIDTH-1:7];

  always_comb begin
    w_cmd = '0;
    case ({r_bank, r_op})
      2'b00:   w_cmd[0] = 1'b1;
      2'b01:   w_cmd[1] = 1'b1;
      2'b10:   w_cmd[2] = 1'b1;
      default: w_cmd[3] = 1'b1;
    endcase
    w_cmd[11:4]  = r_be;
    w_cmd[18:16] = r_word_sel;
    w_cmd[26:20] = r_burst;
  end

  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_timer_nxt      = r_timer;
    w_guard_nxt      = r_guard;
    w_rsp_data_nxt   = r_rsp_data;
    w_rsp_status_nxt = r_rsp_status;
    w_accept         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_accept     = 1'b1;
          w_timer_nxt  = '0;
          w_next_state = S_CHK_FULL;
        end
      end
      S_CHK_FULL: begin
        if (!w_fifo_full) begin
          w_next_state = S_ISSUE;
        end else if (r_timer == c_tmr_last) begin
          w_rsp_data_nxt   = '0;
          w_rsp_status_nxt = c_st_seq_to;
          w_next_state     = S_RESP;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_ISSUE: begin
        w_guard_nxt  = '0;
        w_next_state = S_GUARD;
      end
      S_GUARD: begin
        if (r_guard != c_grd_last) begin
          w_guard_nxt = r_guard + GRD_W'(1);
        end else if (r_op) begin
          w_timer_nxt  = '0;
          w_next_state = S_WAIT_DATA;
        end else begin
          w_rsp_data_nxt   = '0;
          w_rsp_status_nxt = w_wr_timeout ? c_st_dev_to : c_st_ok;
          w_next_state     = S_RESP;
        end
      end
      S_WAIT_DATA: begin
        if (w_data_valid) begin
          w_rsp_data_nxt   = mem2cr_readdata;
          w_rsp_status_nxt = c_st_ok;
          w_next_state     = S_RESP;
        end else if (w_rd_timeout) begin
          w_rsp_data_nxt   = '0;
          w_rsp_status_nxt = c_st_dev_to;
          w_next_state     = S_RESP;
        end else if (r_timer == c_tmr_last) begin
          w_rsp_data_nxt   = '0;
          w_rsp_status_nxt = c_st_seq_to;
          w_next_state     = S_RESP;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Every output is registered from the next-state decision so it lines up
  // with the state it belongs to.
  always_ff @(posedge pClk) begin
    if (SoftReset) begin
      r_timer      <= '0;
      r_guard      <= '0;
      r_op         <= 1'b0;
      r_bank       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= '0;
      r_word_sel   <= '0;
      r_burst      <= '0;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= '0;
      r_ctrl       <= '0;
      r_cr_addr    <= '0;
      r_cr_wdata   <= '0;
      r_busy       <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_timer      <= w_timer_nxt;
      r_guard      <= w_guard_nxt;
      r_req_ready  <= (w_next_state == S_IDLE);
      r_busy       <= (w_next_state != S_IDLE);
      r_rsp_valid  <= (w_next_state == S_RESP);
      r_rsp_data   <= w_rsp_data_nxt;
      r_rsp_status <= w_rsp_status_nxt;
      r_ctrl       <= (w_next_state == S_ISSUE) ? w_cmd : '0;
      if (w_accept) begin
        r_op       <= bus.req_op;
        r_bank     <= bus.req_bank;
        r_addr     <= bus.req_address;
        r_wdata    <= bus.req_writedata;
        r_be       <= bus.req_byteenable;
        r_word_sel <= bus.req_word_sel;
        r_burst    <= bus.req_burstcount;
      end
      // Address/data stay put until the next issue so local_mem's input
      // pipeline sees them stable.
      if (w_next_state == S_ISSUE) begin
        r_cr_addr  <= r_addr;
        r_cr_wdata <= r_wdata;
      end
      if (r_state == S_RESP && bus.rsp_ready && r_rsp_status != c_st_ok &&
          r_err_count != {ERR_CNT_W{1'b1}}) begin
        r_err_count <= r_err_count + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_status   = r_rsp_status;
  assign cr2mem_ctrl      = r_ctrl;
  assign cr2mem_address   = r_cr_addr;
  assign cr2mem_writedata = r_cr_wdata;
  assign busy             = r_busy;
  assign err_count        = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_local_mem_cmd_seq.sv
// ============================================================================
// Module   : tb_local_mem_cmd_seq
// Brief    : Self-checking bench; per-transaction timing model from the
//            sequencer's published cycle rules, randomized status noise.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_local_mem_cmd_seq;

  localparam int DW = 64;
  localparam int G  = 4;
  localparam int TO = 16;
  localparam int EW = 16;

  logic          pClk = 1'b0;
  logic          SoftReset = 1'b1;
  logic [DW-1:0] cr2mem_ctrl, cr2mem_address, cr2mem_writedata;
  logic [DW-1:0] mem2cr_status = '0;
  logic [DW-1:0] mem2cr_readdata = '0;
  logic          busy;
  logic [EW-1:0] err_count;

  int n_checks = 0;
  int n_errs   = 0;
  int m_err    = 0;

  local_mem_cmd_seq_if #(.DATA_WIDTH(DW)) bus ();

  local_mem_cmd_seq #(
    .DATA_WIDTH(DW), .GUARD_CYCLES(G), .TIMEOUT_CYCLES(TO), .ERR_CNT_W(EW)
  ) dut (
    .pClk(pClk), .SoftReset(SoftReset), .bus(bus),
    .cr2mem_ctrl(cr2mem_ctrl), .cr2mem_address(cr2mem_address),
    .cr2mem_writedata(cr2mem_writedata), .mem2cr_status(mem2cr_status),
    .mem2cr_readdata(mem2cr_readdata), .busy(busy), .err_count(err_count)
  );

  always #5 pClk = ~pClk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // kind: 0 data_valid, 1 read timeout flag, 2 nothing, 3 both flags
  task automatic run_txn(input bit op, input bit bank, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] be,
                         input logic [2:0] ws, input logic [6:0] bc, input int F,
                         input bit wto, input int D, input int kind,
                         input logic [63:0] rdata, input int R, input int rst_k);
    logic [63:0] cmd, st, rd, exp_data, exp_ctrl;
    logic [1:0]  exp_st;
    bit          pulse, exp_valid;
    int          kp, kw, ke, kr, kend, w, fb, wb, rb;
    fb = bank ? 6 : 3;
    wb = bank ? 4 : 1;
    rb = bank ? 5 : 2;
    cmd = '0;
    cmd[int'(bank) * 2 + int'(op)] = 1'b1;
    cmd[11:4]  = be;
    cmd[18:16] = ws;
    cmd[26:20] = bc;
    kp = 0; kw = 0; ke = 0;
    if (F >= TO) begin
      pulse = 0; kr = TO + 1; exp_st = 2'b10; exp_data = '0;
    end else begin
      pulse = 1; kp = F + 2; kw = kp + G + 1; ke = kp + D;
      if (!op) begin
        kr = kw; exp_st = wto ? 2'b01 : 2'b00; exp_data = '0;
      end else if (kind != 2 && ke <= kw + TO - 1) begin
        kr = ((ke > kw) ? ke : kw) + 1;
        exp_st   = (kind == 1) ? 2'b01 : 2'b00;
        exp_data = (kind == 1) ? '0 : rdata;
      end else begin
        kr = kw + TO; exp_st = 2'b10; exp_data = '0;
      end
    end
    kend = kr + R + 1;
    if (rst_k == 0 && exp_st != 2'b00 && m_err < 65535) m_err++;

    bus.req_valid = 1'b1; bus.req_op = op; bus.req_bank = bank;
    bus.req_address = addr; bus.req_writedata = wdata; bus.req_byteenable = be;
    bus.req_word_sel = ws; bus.req_burstcount = bc;
    w = 0;
    while (bus.req_ready !== 1'b1 && w < 50) begin
      @(posedge pClk); #1; w++;
    end
    n_checks++;
    if (w >= 50) begin
      n_errs++;
      $display("FAIL accept: req_ready=%b required 1 within 50 cycles", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end

    for (int k = 1; k <= kend; k++) begin
      @(posedge pClk); #1;
      if (k == 1) begin
        bus.req_valid = 1'b0;
        bus.req_op = 1'($urandom); bus.req_bank = 1'($urandom);
        bus.req_address = {$urandom, $urandom};
        bus.req_writedata = {$urandom, $urandom};
        bus.req_byteenable = 8'($urandom); bus.req_word_sel = 3'($urandom);
        bus.req_burstcount = 7'($urandom);
      end
      st = {$urandom, $urandom};
      st[6:0] = '0;
      if (bank) st[3:1] = 3'($urandom); else st[6:4] = 3'($urandom);
      if (k <= F) st[fb] = 1'b1;
      rd = {$urandom, $urandom};
      if (!op) begin
        st[0] = 1'($urandom); st[rb] = 1'($urandom); st[wb] = wto;
      end else begin
        st[wb] = 1'($urandom);
        if (pulse && k >= ke) begin
          if (kind == 0 || kind == 3) begin st[0] = 1'b1; rd = rdata; end
          if (kind == 1 || kind == 3) st[rb] = 1'b1;
        end
      end
      mem2cr_status = st;
      mem2cr_readdata = rd;
      bus.rsp_ready = (k >= kr + R) ? 1'b1 : ((k < kr) ? 1'($urandom) : 1'b0);

      exp_ctrl  = (pulse && k == kp) ? cmd : '0;
      exp_valid = (k >= kr) && (k <= kr + R);
      n_checks++;
      if (cr2mem_ctrl !== exp_ctrl) begin
        n_errs++;
        $display("FAIL ctrl k=%0d got=%h exp=%h", k, cr2mem_ctrl, exp_ctrl);
      end
      if (pulse && k == kp) begin
        n_checks += 2;
        if (cr2mem_address !== addr) begin
          n_errs++;
          $display("FAIL address k=%0d got=%h exp=%h", k, cr2mem_address, addr);
        end
        if (cr2mem_writedata !== wdata) begin
          n_errs++;
          $display("FAIL writedata k=%0d got=%h exp=%h", k, cr2mem_writedata, wdata);
        end
      end
      n_checks += 3;
      if (bus.rsp_valid !== exp_valid) begin
        n_errs++;
        $display("FAIL rsp_valid k=%0d got=%b exp=%b", k, bus.rsp_valid, exp_valid);
      end
      if (busy !== (k <= kr + R)) begin
        n_errs++;
        $display("FAIL busy k=%0d got=%b exp=%b", k, busy, (k <= kr + R));
      end
      if (bus.req_ready !== (k == kend)) begin
        n_errs++;
        $display("FAIL req_ready k=%0d got=%b exp=%b", k, bus.req_ready, (k == kend));
      end
      if (exp_valid) begin
        n_checks += 2;
        if (bus.rsp_data !== exp_data) begin
          n_errs++;
          $display("FAIL rsp_data k=%0d got=%h exp=%h", k, bus.rsp_data, exp_data);
        end
        if (bus.rsp_status !== exp_st) begin
          n_errs++;
          $display("FAIL rsp_status k=%0d got=%b exp=%b", k, bus.rsp_status, exp_st);
        end
      end
      if (k == kend) begin
        n_checks++;
        if (err_count !== EW'(m_err)) begin
          n_errs++;
          $display("FAIL err_count got=%0d exp=%0d", err_count, m_err);
        end
      end
      if (k == rst_k) begin
        SoftReset = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0; bus.req_op = 1'b0;
    bus.req_bank = 1'b0; bus.req_address = '0; bus.req_writedata = '0;
    bus.req_byteenable = '0; bus.req_word_sel = '0; bus.req_burstcount = '0;
    SoftReset = 1'b1;
    repeat (2) begin @(posedge pClk); #1; end
    n_checks += 4;
    if ({bus.req_ready, bus.rsp_valid, busy} !== 3'b000) begin
      n_errs++;
      $display("FAIL reset_flags got=%b exp=000", {bus.req_ready, bus.rsp_valid, busy});
    end
    if (cr2mem_ctrl !== '0 || cr2mem_address !== '0 || cr2mem_writedata !== '0) begin
      n_errs++;
      $display("FAIL reset_cr2mem got=%h/%h/%h exp=0", cr2mem_ctrl, cr2mem_address, cr2mem_writedata);
    end
    if (bus.rsp_data !== '0 || bus.rsp_status !== 2'b00) begin
      n_errs++;
      $display("FAIL reset_rsp got=%h/%b exp=0", bus.rsp_data, bus.rsp_status);
    end
    if (err_count !== '0) begin
      n_errs++;
      $display("FAIL reset_err_count got=%0d exp=0", err_count);
    end
    SoftReset = 1'b0;
    @(posedge pClk); #1;
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_errs++;
      $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready);
    end
  endtask

  task automatic test_write();
    run_txn(1'b0, 1'b0, 64'h40, 64'hDEADBEEF, 8'hFF, 3'd0, 7'd0, 0, 1'b0,
            0, 2, '0, 0, 0);
  endtask

  task automatic test_read();
    run_txn(1'b1, 1'b1, 64'h80, 64'h0, 8'hFF, 3'd3, 7'd1, 0, 1'b0,
            12, 0, 64'h1234, 0, 0);
  endtask

  task automatic test_fifo_full();
    run_txn(1'b0, 1'b1, 64'h100, 64'hCAFEF00D, 8'h0F, 3'd0, 7'd2, 10, 1'b0,
            0, 2, '0, 0, 0);
  endtask

  task automatic test_errors();
    run_txn(1'b1, 1'b0, 64'h200, 64'h0, 8'hFF, 3'd1, 7'd1, 0, 1'b0,
            6, 1, '0, 0, 0);
    run_txn(1'b0, 1'b0, 64'h300, 64'h55, 8'hFF, 3'd0, 7'd1, 1000, 1'b0,
            0, 2, '0, 0, 0);
  endtask

  task automatic test_backpressure();
    run_txn(1'b1, 1'b0, 64'h400, 64'h0, 8'hA5, 3'd7, 7'd64, 2, 1'b0,
            7, 3, 64'h0123_4567_89AB_CDEF, 5, 0);
  endtask

  task automatic test_reset_mid();
    // WAIT_DATA spans cycles 7..22 of a read with no FIFO stall.
    run_txn(1'b1, 1'b1, 64'h500, 64'h0, 8'hFF, 3'd2, 7'd1, 0, 1'b0,
            5, 2, '0, 0, 10);
    bus.req_valid = 1'b0;
    @(posedge pClk); #1;
    n_checks += 3;
    if ({bus.req_ready, bus.rsp_valid, busy} !== 3'b000) begin
      n_errs++;
      $display("FAIL midreset_flags got=%b exp=000", {bus.req_ready, bus.rsp_valid, busy});
    end
    if (cr2mem_ctrl !== '0 || cr2mem_address !== '0 || bus.rsp_data !== '0 ||
        bus.rsp_status !== 2'b00) begin
      n_errs++;
      $display("FAIL midreset_outputs got=%h/%h/%h/%b exp=0", cr2mem_ctrl, cr2mem_address,
               bus.rsp_data, bus.rsp_status);
    end
    if (err_count !== '0) begin
      n_errs++;
      $display("FAIL midreset_err_count got=%0d exp=0", err_count);
    end
    SoftReset = 1'b0;
    m_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge pClk); #1;
      n_checks += 2;
      if (bus.rsp_valid !== 1'b0) begin
        n_errs++;
        $display("FAIL midreset_no_rsp i=%0d got=%b exp=0", i, bus.rsp_valid);
      end
      if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
        n_errs++;
        $display("FAIL midreset_idle i=%0d got=%b%b exp=10", i, bus.req_ready, busy);
      end
    end
    run_txn(1'b0, 1'b1, 64'h600, 64'hFEED, 8'h3C, 3'd0, 7'd1, 0, 1'b0,
            0, 2, '0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 12; t++) begin
      run_txn(1'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
              8'($urandom), 3'($urandom), 7'($urandom),
              ($urandom_range(0, 6) == 0) ? 20 : $urandom_range(0, 4),
              ($urandom_range(0, 3) == 0), $urandom_range(5, 24),
              $urandom_range(0, 3), {$urandom, $urandom}, $urandom_range(0, 3), 0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/local_mem_cmd_seq.md
Name: local_mem_cmd_seq

Overview:
Command sequencer in front of local_mem's CSR-style control port. It accepts one memory transaction at a time through a valid/ready request channel and translates it into a single-cycle cr2mem_ctrl pulse with stable address and write data. It then monitors mem2cr_status for FIFO-full, data-valid and timeout flags, and returns a response with read data and a completion status. It replaces software polling of the mem2cr_status register.

Parameters:
DATA_WIDTH, 64, width of the CSR data, address and status words
GUARD_CYCLES, 4, cycles to wait after the ctrl pulse before status is trusted; must be ≥3
TIMEOUT_CYCLES, 4096, sequencer-side timeout for FIFO-full wait and read-data wait
ERR_CNT_W, 16, width of the error counter

Ports:
pClk  in  1  clock
SoftReset  in  1  synchronous active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_op  in  1  0 = write, 1 = read
req_bank  in  1  0 = bank a (local_mem[0]), 1 = bank b (local_mem[1])
req_address  in  DATA_WIDTH  word address
req_writedata  in  DATA_WIDTH  write data
req_byteenable  in  8  byte enables
req_word_sel  in  3  read word select
req_burstcount  in  7  burst count
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_data  out  DATA_WIDTH  read data; 0 for writes
rsp_status  out  2  00 = ok, 01 = device timeout, 10 = sequencer timeout, 11 = reserved
cr2mem_ctrl  out  DATA_WIDTH  control word to local_mem
cr2mem_address  out  DATA_WIDTH  address to local_mem
cr2mem_writedata  out  DATA_WIDTH  write data to local_mem
mem2cr_status  in  DATA_WIDTH  status from local_mem
mem2cr_readdata  in  DATA_WIDTH  read data from local_mem
busy  out  1  high whenever the FSM is not in IDLE
err_count  out  ERR_CNT_W  saturating count of non-ok responses

Behaviour:
- Reset values: all outputs registered and reset to 0 (req_ready, rsp_*, cr2mem_*, busy, err_count). FSM resets to IDLE, timer to 0. A request in flight is dropped with no response. Outputs reach reset values the cycle after SoftReset is sampled high.
- Status bit map (mem2cr_status):
  - bit 0: data_valid
  - bank a: bit 1 write timeout, bit 2 read timeout, bit 3 cmd FIFO full
  - bank b: bit 4 write timeout, bit 5 read timeout, bit 6 cmd FIFO full
- FSM states: IDLE, CHK_FULL, ISSUE, GUARD, WAIT_DATA, RESP.
- IDLE:
  - req_ready = 1 only in IDLE.
  - On handshake, latch all request fields and go to CHK_FULL; timer cleared.
- CHK_FULL:
  - If the selected bank's FIFO-full bit is 0, go to ISSUE.
  - Otherwise increment the timer. When the timer reaches TIMEOUT_CYCLES-1, go to RESP with status 10 and issue nothing.
- ISSUE: for exactly one cycle cr2mem_ctrl carries the command, then returns to 0. Command encoding:
  - write bit 0 (bank a) or bit 2 (bank b) when req_op = 0
  - read bit 1 (bank a) or bit 3 (bank b) when req_op = 1
  - [11:4] = byteenable, [18:16] = word_sel, [26:20] = burstcount, all other bits 0
- Address and write data: cr2mem_address and cr2mem_writedata are driven from the latched request from the ISSUE cycle until the next request is accepted, so they are stable through local_mem's 2-stage input pipeline.
- GUARD:
  - Count GUARD_CYCLES cycles.
  - On the last GUARD cycle, a write goes to RESP: status 01 if the bank's write-timeout bit is set, else 00.
  - A read goes to WAIT_DATA with the timer cleared.
- WAIT_DATA, priority high to low:
  1. status bit 0 = 1: capture mem2cr_readdata into rsp_data, status 00.
  2. Bank read-timeout bit = 1: status 01, rsp_data = 0.
  3. Timer reaches TIMEOUT_CYCLES-1: status 10.
  Any of these goes to RESP.
- RESP:
  - rsp_valid held with rsp_data and rsp_status stable until rsp_ready.
  - On handshake go to IDLE. err_count increments (saturating at all-ones) if status ≠ 00.
  - rsp_valid deasserts the cycle after the handshake.
- Latency (write, FIFO not full, request accepted in cycle T, rsp_ready held high): CHK_FULL in T+1; ctrl pulse visible in T+2; GUARD T+3..T+2+GUARD_CYCLES; rsp_valid at T+3+GUARD_CYCLES (T+7 by default).
- Back-to-back: the earliest next req_ready is the cycle after the response handshake. Only one transaction is ever outstanding, so there is no request/response overlap.
- Timer width is $clog2(TIMEOUT_CYCLES)+1 and it never wraps.

Test Plan:
1. Write bank a, addr 0x40, data 0xDEADBEEF, be 0xFF, status 0 → one-cycle cr2mem_ctrl = 0x0000_0FF1 at T+2; rsp_valid at T+7 with status 00, rsp_data 0; err_count stays 0.
2. Read bank b, word_sel 3, burst 1; bench raises status bit 0 with readdata 0x1234 twelve cycles after the pulse → ctrl pulse = 0x0013_0FF8; rsp_data 0x1234, status 00.
3. Bank b FIFO full (bit 6) held for 10 cycles, then cleared → no ctrl pulse while full; pulse on the 2nd cycle after bit 6 drops; normal completion.
4. Read bank a, bit 2 asserted and data_valid never set → status 01, rsp_data 0; err_count = 1. Then FIFO full held forever with TIMEOUT_CYCLES = 16 → status 10 after 16 CHK_FULL cycles, no pulse; err_count = 2.
5. rsp_ready held low for 5 cycles → rsp_valid, rsp_data and rsp_status stable throughout; req_ready stays 0 until after the handshake.
6. SoftReset asserted during WAIT_DATA → next cycle all outputs 0 and FSM IDLE, no response ever issued; a fresh write afterwards completes normally.
